// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// instruction size, PC read offset, default reset PC and the instruction
// field positions used to slice Op/Funct/Cond out of the held instruction.
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      DROP  = 2'd3
   } fetch_state_e;

   localparam int INSTR_BYTES    = 4;
   localparam int PC_READ_OFFSET = 8;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instruction field positions and widths
   localparam int OP_LSB    = 26;
   localparam int OP_W      = 2;
   localparam int FUNCT_LSB = 20;
   localparam int FUNCT_W   = 6;
   localparam int COND_LSB  = 28;
   localparam int COND_W    = 4;

endpackage : fetch_pkg

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter plus pending redirect target for the fetch stage.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset, PC returns to RESET_PC
//   consume_i    held instruction consumed: PC advances by one word
//   redirect_i   branch redirect: target is taken (now or once the
//                outstanding fetch completes)
//   defer_i      a fetch is outstanding without ack this cycle, so a redirect
//                only updates the pending target and the PC keeps addressing
//                the stale request
//   drop_done_i  stale fetch acknowledged: PC takes the pending target
//   target_i     redirect address, low two bits ignored
//   pc_o         current program counter
// -----------------------------------------------------------------------------
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              consume_i,
   input  logic              redirect_i,
   input  logic              defer_i,
   input  logic              drop_done_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_q, pend_d;
   logic [ADDR_W-1:0] target_aligned;

   assign target_aligned = target_i & ~ADDR_W'(2'b11);

   // Redirect wins over everything; the pending target is always refreshed so
   // the latest redirect seen during a drop is the one that is fetched.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      pc_d   = pc_q;
      pend_d = pend_q;
      if (redirect_i) begin
         pend_d = target_aligned;
         if (!defer_i) begin
            pc_d = target_aligned;
         end
      end else if (drop_done_i) begin
         pc_d = pend_q;
      end else if (consume_i) begin
         pc_d = pc_q + ADDR_W'(INSTR_BYTES);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         pend_q <= RESET_PC;
      end else begin
         pc_q   <= pc_d;
         pend_q <= pend_d;
      end
   end

   assign pc_o = pc_q;

endmodule : fetch_pc_reg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage for the single-cycle ARM-subset processor. Fetches
// one word at a time over a req/ack interface, holds it for the decoder and
// exposes its Op/Funct/Cond fields and PC+8. Branch redirects discard stale
// fetches; consumed instructions are counted.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   imem_req/imem_addr      fetch request and word-aligned address
//   imem_ack/imem_rdata     memory response (ack may come with req)
//   stall                   downstream not consuming this cycle
//   PCSrc/BranchTarget      redirect request and target address
//   Instr/InstrValid        held instruction and its valid flag
//   Op/Funct/Cond           field slices of Instr
//   PCPlus8                 address of held instruction + 8
//   InstrCount              consumed instruction count (wraps)
// -----------------------------------------------------------------------------
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   input  logic                stall,
   input  logic                PCSrc,
   input  logic [ADDR_W-1:0]   BranchTarget,
   output logic [31:0]         Instr,
   output logic                InstrValid,
   output logic [OP_W-1:0]     Op,
   output logic [FUNCT_W-1:0]  Funct,
   output logic [COND_W-1:0]   Cond,
   output logic [ADDR_W-1:0]   PCPlus8,
   output logic [31:0]         InstrCount
);

   fetch_state_e      state_q;
   logic              req_q;
   logic              valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc_plus8_q;
   logic [31:0]       count_q;

   logic [ADDR_W-1:0] pc;
   logic              consume;
   logic              defer;
   logic              drop_done;

   // A redirect in VALID invalidates rather than consumes.
   assign consume   = (state_q == VALID) && !stall && !PCSrc;
   // Request outstanding with no ack yet: a redirect has to wait for it.
   assign defer     = ((state_q == FETCH) || (state_q == DROP)) && !imem_ack;
   assign drop_done = (state_q == DROP) && imem_ack;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .reset       (reset),
      .consume_i   (consume),
      .redirect_i  (PCSrc),
      .defer_i     (defer),
      .drop_done_i (drop_done),
      .target_i    (BranchTarget),
      .pc_o        (pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_plus8_q <= RESET_PC + ADDR_W'(PC_READ_OFFSET);
         count_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            FETCH: begin
               if (PCSrc) begin
                  // With ack the data is simply dropped and the new PC is
                  // fetched next; without ack the request must complete first.
                  state_q <= imem_ack ? FETCH : DROP;
               end else if (imem_ack) begin
                  state_q    <= VALID;
                  req_q      <= 1'b0;
                  valid_q    <= 1'b1;
                  instr_q    <= imem_rdata;
                  pc_plus8_q <= pc + ADDR_W'(PC_READ_OFFSET);
               end
            end
            VALID: begin
               if (PCSrc || !stall) begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
                  if (!PCSrc) begin
                     count_q <= count_q + 32'd1;
                  end
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc;
   assign Instr      = instr_q;
   assign InstrValid = valid_q;
   assign Op         = instr_q[OP_LSB +: OP_W];
   assign Funct      = instr_q[FUNCT_LSB +: FUNCT_W];
   assign Cond       = instr_q[COND_LSB +: COND_W];
   assign PCPlus8    = pc_plus8_q;
   assign InstrCount = count_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A memory model with programmable wait
// states answers fetches; a model of the delivered instruction stream (next
// address, consumed count) is compared against the DUT every cycle, and
// directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic [31:0] Instr;
   logic        InstrValid;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Cond;
   logic [31:0] PCPlus8;
   logic [31:0] InstrCount;

   int tests = 0;
   int fails = 0;

   instr_fetch #(
      .ADDR_W   (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .PCSrc        (PCSrc),
      .BranchTarget (BranchTarget),
      .Instr        (Instr),
      .InstrValid   (InstrValid),
      .Op           (Op),
      .Funct        (Funct),
      .Cond         (Cond),
      .PCPlus8      (PCPlus8),
      .InstrCount   (InstrCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hE281_1001;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // ---------------------------------------------------------------------------
   // Memory + reference model, evaluated at the falling edge
   // ---------------------------------------------------------------------------
   int          waits = 0;
   int          wcnt  = 0;
   logic [31:0] exp_addr  = RST_PC;   // address of the next instruction to deliver
   logic [31:0] exp_count = '0;
   logic        prev_req  = 1'b0;
   logic        prev_ack  = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] exp_word;

   initial begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
   end

   always @(negedge clk) begin
      if (reset) begin
         exp_addr  = RST_PC;
         exp_count = '0;
         prev_req  = 1'b0;
         prev_ack  = 1'b0;
         wcnt      = 0;
         imem_ack  = 1'b0;
      end else begin
         // Outputs this cycle against the model
         check("count", InstrCount, exp_count);
         if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
         if (prev_req && !prev_ack) begin
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_held", imem_addr, prev_addr);
         end
         if (InstrValid) begin
            exp_word = mem_word(exp_addr);
            check("instr", Instr, exp_word);
            check("pc_plus8", PCPlus8, exp_addr + 32'd8);
            check("op", {30'd0, Op}, (exp_word >> 26) & 32'h3);
            check("funct", {26'd0, Funct}, (exp_word >> 20) & 32'h3F);
            check("cond", {28'd0, Cond}, exp_word >> 28);
            check("no_req_when_valid", {31'd0, imem_req}, 32'd0);
         end

         // Memory response for the coming edge
         if (imem_req) begin
            if (wcnt >= waits) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_word(imem_addr);
               wcnt       = 0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = 32'hDEAD_BEEF;
               wcnt++;
            end
         end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
         end
         prev_req  = imem_req;
         prev_ack  = imem_ack;
         prev_addr = imem_addr;

         // What the coming edge does to the delivered stream
         if (PCSrc) begin
            exp_addr = BranchTarget & ~32'h3;
         end else if (InstrValid && !stall) begin
            exp_count = exp_count + 32'd1;
            exp_addr  = exp_addr + 32'd4;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max_cycles);
      int n;
      n = 0;
      while (!InstrValid && n < max_cycles) begin
         cyc();
         n++;
      end
      check("wait_valid_timeout", {31'd0, InstrValid}, 32'd1);
   endtask

   task automatic wait_addr_change(input logic [31:0] old_addr, input int max_cycles);
      int n;
      n = 0;
      while (imem_addr == old_addr && n < max_cycles) begin
         check("stale_not_valid", {31'd0, InstrValid}, 32'd0);
         cyc();
         n++;
      end
   endtask

   initial begin
      reset        = 1'b1;
      stall        = 1'b1;
      PCSrc        = 1'b0;
      BranchTarget = '0;
      repeat (2) cyc();

      // Reset values
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0000_0100);
      check("rst_instr", Instr, 32'd0);
      check("rst_fields", {20'd0, Cond, Op, Funct}, 32'd0);
      check("rst_valid", {31'd0, InstrValid}, 32'd0);
      check("rst_pc8", PCPlus8, 32'h0000_0108);
      check("rst_count", InstrCount, 32'd0);

      // Reset and first fetch, zero-wait memory
      reset = 1'b0;
      cyc();
      check("c1_req", {31'd0, imem_req}, 32'd1);
      check("c1_addr", imem_addr, 32'h0000_0100);
      cyc();
      check("c2_valid", {31'd0, InstrValid}, 32'd1);
      check("c2_op", {30'd0, Op}, 32'h0);
      check("c2_funct", {26'd0, Funct}, 32'h28);
      check("c2_cond", {28'd0, Cond}, 32'hE);
      check("c2_pc8", PCPlus8, 32'h0000_0108);

      // Stall hold
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("stall_instr", Instr, 32'hE281_1001);
         check("stall_pc8", PCPlus8, 32'h0000_0108);
         check("stall_req", {31'd0, imem_req}, 32'd0);
         check("stall_count", InstrCount, 32'd0);
      end
      stall = 1'b0;
      cyc();
      check("after_stall_addr", imem_addr, 32'h0000_0104);
      check("after_stall_count", InstrCount, 32'd1);
      stall = 1'b1;
      cyc();
      check("v104_valid", {31'd0, InstrValid}, 32'd1);

      // Redirect one cycle into a 3-wait-state fetch
      waits = 3;
      stall = 1'b0;
      cyc();
      check("f108_addr", imem_addr, 32'h0000_0108);
      stall        = 1'b1;
      PCSrc        = 1'b1;
      BranchTarget = 32'h0000_0200;
      cyc();
      PCSrc = 1'b0;
      check("drop_req", {31'd0, imem_req}, 32'd1);
      check("drop_addr", imem_addr, 32'h0000_0108);
      wait_addr_change(32'h0000_0108, 10);
      check("redir_addr", imem_addr, 32'h0000_0200);
      check("redir_req", {31'd0, imem_req}, 32'd1);
      wait_valid(20);

      // Double redirect while dropping: latest target wins (low bits ignored)
      stall = 1'b0;
      cyc();
      check("f204_addr", imem_addr, 32'h0000_0204);
      stall        = 1'b1;
      PCSrc        = 1'b1;
      BranchTarget = 32'h0000_0200;
      cyc();
      BranchTarget = 32'h0000_0303;
      cyc();
      PCSrc = 1'b0;
      wait_addr_change(32'h0000_0204, 10);
      check("dbl_redir_addr", imem_addr, 32'h0000_0300);
      wait_valid(20);

      // Redirect in VALID with stall low: not counted
      check("pre_v_redir_count", InstrCount, 32'd3);
      stall        = 1'b0;
      PCSrc        = 1'b1;
      BranchTarget = 32'h0000_0400;
      cyc();
      check("v_redir_count", InstrCount, 32'd3);
      check("v_redir_addr", imem_addr, 32'h0000_0400);
      check("v_redir_valid", {31'd0, InstrValid}, 32'd0);
      PCSrc = 1'b0;
      stall = 1'b1;
      wait_valid(20);

      // Redirect with ack in the same cycle, zero-wait memory
      waits = 0;
      stall = 1'b0;
      cyc();
      check("f404_addr", imem_addr, 32'h0000_0404);
      stall        = 1'b1;
      PCSrc        = 1'b1;
      BranchTarget = 32'h0000_0500;
      cyc();
      PCSrc = 1'b0;
      check("ack_redir_addr", imem_addr, 32'h0000_0500);
      check("ack_redir_req", {31'd0, imem_req}, 32'd1);
      check("ack_redir_valid", {31'd0, InstrValid}, 32'd0);
      cyc();
      check("ack_redir_instr", Instr, mem_word(32'h0000_0500));
      check("ack_redir_pc8", PCPlus8, 32'h0000_0508);

      // Wrap-around of PC and counter
      PCSrc        = 1'b1;
      BranchTarget = 32'hFFFF_FFFC;
      cyc();
      PCSrc = 1'b0;
      cyc();
      check("wrap_valid", {31'd0, InstrValid}, 32'd1);
      check("wrap_pc8", PCPlus8, 32'h0000_0004);
      force dut.count_q = 32'hFFFF_FFFF;
      exp_count = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      waits = 3;
      stall = 1'b0;
      cyc();
      stall = 1'b1;
      check("wrap_addr", imem_addr, 32'h0000_0000);
      check("wrap_count", InstrCount, 32'h0000_0000);

      // Reset while a fetch is outstanding
      reset = 1'b1;
      #1;
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_addr", imem_addr, 32'h0000_0100);
      check("midrst_count", InstrCount, 32'd0);
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      check("post_rst_req", {31'd0, imem_req}, 32'd1);
      check("post_rst_addr", imem_addr, 32'h0000_0100);
      wait_valid(20);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_instr_fetch
